// File: rtl/led_fader_pkg.sv
// led_fader_pkg: shared widths and constants for the cylon LED afterglow fader.
// Consumers import this package with import led_fader_pkg::*.
package led_fader_pkg;

  // Default brightness / PWM counter width in bits.
  localparam int MXPWM_DEFAULT = 4;

  // Default decay prescaler width in bits.
  localparam int MXDECAY_DEFAULT = 18;

  // Full-on brightness at the default width (all ones).
  localparam logic [MXPWM_DEFAULT-1:0] BMAX = {MXPWM_DEFAULT{1'b1}};

  // Number of LED channels driven by the fader.
  localparam int NUM_CHAN = 8;

endpackage

// File: rtl/led_fader_chan.sv
// led_fader_chan: one LED channel -- brightness register with saturating decay,
// duty computation and registered PWM compare.
// Optional macro LED_FADER_GAMMA_EN selects a squared (perceptual) duty curve;
// without it the duty is the brightness itself.
module led_fader_chan
  import led_fader_pkg::*;
#(
  parameter int MXPWM = MXPWM_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic             i_pattern,
  input  logic             i_decayTick,
  input  logic [MXPWM-1:0] i_pwmCnt,
  output logic             o_led
);

  localparam logic [MXPWM-1:0] CHAN_BMAX = {MXPWM{1'b1}};

  logic [MXPWM-1:0] r_brightness;
  logic [MXPWM-1:0] w_duty;
  logic             r_led;

`ifdef LED_FADER_GAMMA_EN
  logic [2*MXPWM-1:0] w_brightWide;
  logic [2*MXPWM-1:0] w_square;

  // Squaring the brightness and keeping the top half gives a gentler tail.
  assign w_brightWide = {{MXPWM{1'b0}}, r_brightness};
  assign w_square     = w_brightWide * w_brightWide;
  assign w_duty       = MXPWM'(w_square >> MXPWM);
`else
  assign w_duty = r_brightness;
`endif

  // Brightness: a lit eye reloads full-on, otherwise fade one step per decay tick down to dark.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_brightness <= '0;
    end else if (!i_enable) begin
      r_brightness <= '0;
    end else if (i_pattern) begin
      r_brightness <= CHAN_BMAX;
    end else if (i_decayTick && (r_brightness != '0)) begin
      r_brightness <= r_brightness - MXPWM'(1);
    end
  end

  // Output register: full brightness is solid on, anything less is PWM against the shared counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= 1'b0;
    end else if (!i_enable) begin
      r_led <= 1'b0;
    end else begin
      r_led <= (r_brightness == CHAN_BMAX) || (i_pwmCnt < w_duty);
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_fader.sv
// led_fader: afterglow fader for the cylon eye. Shared PWM counter and decay
// prescaler live here; eight led_fader_chan instances hold the per-LED state.
// Optional macro LED_FADER_GAMMA_EN (applied inside led_fader_chan) selects a
// perceptual duty curve.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int MXPWM   = MXPWM_DEFAULT,
  parameter int MXDECAY = MXDECAY_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_CHAN-1:0] pattern_in,
  input  logic                enable,
  input  logic [1:0]          decay_rate,
  output logic [NUM_CHAN-1:0] led_out
);

  logic [MXPWM-1:0]    r_pwmCnt;
  logic [MXDECAY-1:0]  r_prescaler;
  logic [MXDECAY:0]    w_step;
  logic [MXDECAY:0]    w_sum;
  logic                w_decayTick;
  logic [NUM_CHAN-1:0] w_led;

  // The decay tick is the carry out of the prescaler add, so a faster rate simply wraps sooner.
  assign w_step      = (MXDECAY+1)'(decay_rate) + (MXDECAY+1)'(1);
  assign w_sum       = {1'b0, r_prescaler} + w_step;
  assign w_decayTick = enable & w_sum[MXDECAY];

  // Shared timebase: PWM counter and decay prescaler run only while enabled and clear otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pwmCnt    <= '0;
      r_prescaler <= '0;
    end else if (!enable) begin
      r_pwmCnt    <= '0;
      r_prescaler <= '0;
    end else begin
      r_pwmCnt    <= r_pwmCnt + MXPWM'(1);
      r_prescaler <= w_sum[MXDECAY-1:0];
    end
  end

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
    led_fader_chan #(
      .MXPWM(MXPWM)
    ) u_chan (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_enable    (enable),
      .i_pattern   (pattern_in[g]),
      .i_decayTick (w_decayTick),
      .i_pwmCnt    (r_pwmCnt),
      .o_led       (w_led[g])
    );
  end

  assign led_out = w_led;

endmodule
